// File: rtl/svm_seq_engine.sv
// svm_seq_engine: sequential one-vs-one SVM decision engine.
// Accumulates one weight*feature product per cycle. It then strobes the sign of
// (sum + bias) and repeats this for every decision of one DAG classification.
module svm_seq_engine #(
   parameter int unsigned N_features   = 16,
   parameter int unsigned featureWidth = 4,
   parameter int unsigned weightWidth  = 8,
   parameter int unsigned biasWidth    = 16,
   parameter int unsigned N_classes    = 10
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic        [featureWidth*N_features-1:0]   features,
   input  logic signed [weightWidth*N_features-1:0]    weight,
   input  logic signed [biasWidth-1:0]                 bia,
   output logic                                        svmready,
   output logic                                        w_class,
   output logic                                        busy,
   output logic                                        done
);

   localparam int unsigned PROD_W = featureWidth + weightWidth + 1;
   localparam int unsigned ACC_W  = PROD_W + $clog2(N_features);
   localparam int unsigned D_W    = ((ACC_W > biasWidth) ? ACC_W : biasWidth) + 1;
   localparam int unsigned K_W    = (N_features > 1) ? $clog2(N_features) : 1;
   localparam int unsigned DC_W   = (N_classes > 2) ? $clog2(N_classes) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACC    = 2'd1,
      S_DECIDE = 2'd2
   } state_t;

   state_t                              r_state;
   logic [featureWidth*N_features-1:0]  r_feat_q;
   logic signed [ACC_W-1:0]             r_acc;
   logic [K_W-1:0]                      r_k;
   logic [DC_W-1:0]                     r_dcnt;

   logic        [featureWidth-1:0]      w_feat_arr [N_features];
   logic signed [weightWidth-1:0]       w_wt_arr   [N_features];
   logic signed [featureWidth:0]        w_feat_s;
   logic signed [PROD_W-1:0]            w_prod;
   logic signed [ACC_W-1:0]             w_acc_next;
   logic signed [D_W-1:0]               w_d;
   logic                                w_last_k;
   logic                                w_last_dec;
   logic                                w_dec_pos;

   // Unpack the latched features and the live weights into per-index lanes
   always_comb begin
      for (int i = 0; i < int'(N_features); i++) begin
         w_feat_arr[i] = r_feat_q[i*featureWidth +: featureWidth];
         w_wt_arr[i]   = weight[i*weightWidth +: weightWidth];
      end
   end

   // Current product, running sum including it, and the biased decision value
   always_comb begin
      w_feat_s   = $signed({1'b0, w_feat_arr[r_k]});
      w_prod     = PROD_W'(w_feat_s) * PROD_W'(w_wt_arr[r_k]);
      w_acc_next = r_acc + ACC_W'(w_prod);
      w_d        = D_W'(w_acc_next) + D_W'(bia);
      w_dec_pos  = (w_d >= $signed(D_W'(0)));
      w_last_k   = (r_k == K_W'(N_features - 1));
      w_last_dec = (r_dcnt == DC_W'(N_classes - 1));
   end

   // Control FSM with registered outputs. The decision is registered on the
   // closing edge of the last ACC cycle, so the strobe is visible in DECIDE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_feat_q <= '0;
         r_acc    <= '0;
         r_k      <= '0;
         r_dcnt   <= '0;
         svmready <= 1'b0;
         w_class  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         svmready <= 1'b0;
         done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_feat_q <= features;
                  r_acc    <= '0;
                  r_k      <= '0;
                  r_dcnt   <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_ACC;
               end
            end
            S_ACC: begin
               r_acc <= w_acc_next;
               r_k   <= r_k + K_W'(1);
               if (w_last_k) begin
                  w_class  <= w_dec_pos;
                  svmready <= 1'b1;
                  r_dcnt   <= r_dcnt + DC_W'(1);
                  r_state  <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               if (w_last_dec) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_state <= S_ACC;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_svm_seq_engine.sv
// Self-checking bench for svm_seq_engine: a cycle-count reference model plus a
// DAG picker that feeds per-pair weights back to the engine.
module tb_svm_seq_engine;

   localparam int NF  = 16;
   localparam int FW  = 4;
   localparam int WW  = 8;
   localparam int BW  = 16;
   localparam int NC  = 10;
   localparam int PER = NF + 1;
   localparam int TOT = (NC - 1) * PER;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       start;
   logic        [FW*NF-1:0]    features;
   logic signed [WW*NF-1:0]    weight;
   logic signed [BW-1:0]       bia;
   logic                       svmready;
   logic                       w_class;
   logic                       busy;
   logic                       done;

   svm_seq_engine dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .features (features),
      .weight   (weight),
      .bia      (bia),
      .svmready (svmready),
      .w_class  (w_class),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state: m_t = cycles since start was accepted, 0 = idle
   int m_t      = 0;
   int m_wc     = 0;
   int m_feat [NF];
   bit chk_en   = 1'b0;

   // picker state
   int p_lo     = 0;
   int p_hi     = NC - 1;
   bit const_mode = 1'b1;
   int c_w      = 0;
   int c_b      = 0;
   int strobes  = 0;
   int last_st  = 0;
   int winner   = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
      end
   endtask

   function automatic int pw(input int lo, input int hi, input int k);
      if (const_mode) return c_w;
      return ((lo*37 + hi*11 + k*5 + lo*k*3) % 256) - 128;
   endfunction

   function automatic int pb(input int lo, input int hi);
      if (const_mode) return c_b;
      return ((lo*131 + hi*71 + lo*hi*13) % 4000) - 2000;
   endfunction

   function automatic int decide_d(input int f [NF], input int lo, input int hi);
      int s = pb(lo, hi);
      for (int k = 0; k < NF; k++) s += f[k] * pw(lo, hi, k);
      return s;
   endfunction

   // software DAG prediction: drop the lower class when the decision is >= 0
   function automatic int predict(input int f [NF]);
      int lo = 0;
      int hi = NC - 1;
      while (lo < hi) begin
         if (decide_d(f, lo, hi) >= 0) lo++;
         else hi--;
      end
      return lo;
   endfunction

   task automatic drive_pair();
      for (int k = 0; k < NF; k++) weight[k*WW +: WW] = WW'(pw(p_lo, p_hi, k));
      bia = BW'(pb(p_lo, p_hi));
   endtask

   task automatic set_feats(input int f [NF]);
      for (int k = 0; k < NF; k++) features[k*FW +: FW] = FW'(f[k]);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n == 0) chk("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (svmready === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n == 0) chk("strobe_timeout", 0, 1);
   endtask

   // compare DUT with the model each cycle, run the picker, then advance the model
   always @(negedge clk) begin
      int  exp_busy, exp_sv, exp_done;
      if (chk_en) begin
         exp_busy = (m_t >= 1 && m_t <= TOT) ? 1 : 0;
         exp_sv   = (m_t >= 1 && m_t <= TOT && (m_t % PER) == 0) ? 1 : 0;
         exp_done = (m_t == TOT + 1) ? 1 : 0;
         if (exp_sv != 0) m_wc = (decide_d(m_feat, p_lo, p_hi) >= 0) ? 1 : 0;
         chk("busy", 32'(busy), exp_busy);
         chk("svmready", 32'(svmready), exp_sv);
         chk("done", 32'(done), exp_done);
         chk("w_class", 32'(w_class), m_wc);
         if (svmready === 1'b1) begin
            strobes++;
            if (strobes > 1) chk("strobe_spacing", m_t - last_st, PER);
            last_st = m_t;
            if (w_class === 1'b1) p_lo++;
            else p_hi--;
            drive_pair();
         end
         if (done === 1'b1) winner = p_lo;
      end
      if (rst === 1'b1) begin
         m_t  = 0;
         m_wc = 0;
      end else if ((m_t == 0 || m_t == TOT + 1) && start === 1'b1) begin
         m_t = 1;
         for (int k = 0; k < NF; k++) m_feat[k] = int'(features[k*FW +: FW]);
         p_lo    = 0;
         p_hi    = NC - 1;
         strobes = 0;
         winner  = -1;
         drive_pair();
      end else if (m_t == TOT + 1) begin
         m_t = 0;
      end else if (m_t != 0) begin
         m_t++;
      end
   end

   // constant-weight run: strobe latency, first decision, then drain
   task automatic run_const(input int w, input int b, input int exp_d,
                            input int exp_wc, input string nm);
      int f15 [NF];
      int n;
      for (int k = 0; k < NF; k++) f15[k] = 15;
      const_mode = 1'b1;
      c_w = w;
      c_b = b;
      drive_pair();
      chk({nm, "_model_d"}, decide_d(f15, 0, NC - 1), exp_d);
      set_feats(f15);
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_strobe(n);
      chk({nm, "_latency"}, n, PER);
      chk({nm, "_w_class"}, 32'(w_class), exp_wc);
      wait_done(n);
   endtask

   initial begin
      int fa [NF];
      int fb [NF];
      int fc [NF];
      int n;
      int pred;

      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fa [NF];
      int fb [NF];
      int fc [NF];
      int n;
      int pred;

      rst      = 1'b1;
      start    = 1'b0;
      features = '0;
      drive_pair();
      step(2);
      rst    = 1'b0;
      chk_en = 1'b1;

      // reset and idle
      chk("rst_svmready", 32'(svmready), 0);
      chk("rst_w_class", 32'(w_class), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      step(50);

      // zero boundary and extreme magnitudes
      run_const(1, -240, 0, 1, "zero_d");
      run_const(1, -241, -1, 0, "neg_one");
      run_const(-128, -32768, -63488, 0, "min_ext");
      run_const(127, 32767, 63247, 1, "max_ext");

      // full DAG runs with per-pair weights
      for (int k = 0; k < NF; k++) begin
         fa[k] = (k*7 + 3) % 16;
         fb[k] = (k*k + 5) % 16;
         fc[k] = 15 - k;
      end
      const_mode = 1'b0;

      pred = predict(fa);
      set_feats(fa);
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done(n);
      chk("dagA_done_cycle", n, TOT + 1);
      chk("dagA_strobes", strobes, NC - 1);
      chk("dagA_winner", winner, pred);

      // start re-pulsed mid-ACC and features toggled after start
      pred = predict(fb);
      set_feats(fb);
      start = 1'b1;
      step(1);
      for (int i = 1; i <= 30; i++) begin
         start    = (i == 4);
         features = {$urandom, $urandom};
         step(1);
      end
      start = 1'b0;
      wait_done(n);
      chk("dagB_strobes", strobes, NC - 1);
      chk("dagB_winner", winner, pred);

      // reset (with start also high) in the 5th ACC cycle of decision 3
      set_feats(fc);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(38);
      rst   = 1'b1;
      start = 1'b1;
      step(1);
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_strobes", strobes, 2);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_svmready", 32'(svmready), 0);
      chk("abort_w_class", 32'(w_class), 0);
      step(3);
      chk("abort_idle_busy", 32'(busy), 0);

      pred = predict(fc);
      set_feats(fc);
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done(n);
      chk("dagC_done_cycle", n, TOT + 1);
      chk("dagC_strobes", strobes, NC - 1);
      chk("dagC_winner", winner, pred);

      step(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/svm_seq_engine.md
# svm_seq_engine

Sequential one-vs-one SVM decision engine for the printed-electronics SVM classifiers. It sits between the feature input and the DAG class picker. It accumulates one weight×feature product per cycle using the weight vector and bias the picker currently presents, then returns the binary decision (`w_class`) with a one-cycle `svmready` strobe. It repeats this for the `N_classes-1` decisions of one DAG classification without further prompting.

## Interface
- `N_features`, 16, number of input features.
- `featureWidth`, 4, unsigned feature width.
- `weightWidth`, 8, signed weight width.
- `biasWidth`, 16, signed bias width.
- `N_classes`, 10, number of classes; `N_classes-1` decisions are run per classification.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a classification.
- `features`  in  `featureWidth*N_features`  feature vector; feature k is at bits `[k*featureWidth +: featureWidth]`.
- `weight`  in  signed `weightWidth*N_features`  weight vector from the picker; weight k is laid out the same way as feature k.
- `bia`  in  signed `biasWidth`  bias from the picker.
- `svmready`  out  1  one-cycle decision strobe.
- `w_class`  out  1  decision result: 1 means the higher-index class survives.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the final decision.

## Operation
- Reset values: all outputs 0, FSM in IDLE, `acc`=0, `k`=0, `dcnt`=0.
- FSM states: IDLE, ACC, DECIDE.
- **IDLE**
  - `start`=1: latch `features` into `feat_q`, clear `acc`, `k` and `dcnt`, go to ACC.
  - `start` is ignored outside IDLE.
- **ACC**
  - Each cycle: `acc += $signed({1'b0,feat_q[k]}) * weight[k]`, then `k++`.
  - After the cycle with `k`=`N_features-1`, go to DECIDE.
- **DECIDE**
  - Compute `d = acc + sign-extended bia`.
  - `w_class <= (d >= 0)`; `svmready <= 1` for exactly one cycle.
  - `dcnt++`. If `dcnt` now equals `N_classes-1`, pulse `done` and go to IDLE. Otherwise clear `acc` and `k` and go to ACC.
- Width rules:
  - Product width is `featureWidth+weightWidth+1`.
  - `acc` width is the product width plus `$clog2(N_features)`.
  - `d` width is `max(acc width, biasWidth)+1`.
  - No saturation is applied; the widths are sized so overflow cannot occur.
- `weight` and `bia` are sampled live every ACC cycle. The picker must hold them stable from the cycle after an `svmready` until the next `svmready`.
- `feat_q` is held for the entire classification. Changes on `features` after `start` have no effect.
- `w_class` holds its last value between strobes and is cleared only by `rst`.

## Timing
- Edge 0: `start` sampled in IDLE.
- Cycles 1..`N_features`: ACC.
- Cycle `N_features+1`: `svmready`=1 and `w_class` is valid.
- The picker samples `svmready` and `w_class` on the closing edge of the strobe cycle. Its new `weight`/`bia` must be valid in the following cycle, which is the first ACC cycle of the next decision. No bubble is inserted.
- Decision period is `N_features+1` cycles. A full classification takes `(N_classes-1)*(N_features+1)` cycles (153 with the defaults).
- `done` is asserted in the cycle after the last `svmready`, and `busy` falls in that same cycle.
- A new `start` is accepted in the cycle in which `done` is high, or later.
- `rst` in any state takes effect at the next edge: return to IDLE, no `svmready`/`done` pulse, partial accumulation discarded.
- `start` and `rst` both high: `rst` wins.

## Test plan
- Reset and idle: assert `rst` for 2 cycles, hold `start`=0 → every output is 0 and no `svmready` appears for 50 cycles.
- Zero-boundary decision: all features 15, all weights +1, `bia`=-240 → `svmready` pulses 17 cycles after `start` with `w_class`=1 (d=0). Repeat with `bia`=-241 → `w_class`=0.
- Extreme magnitude: all features 15, all weights -128, `bia`=-32768 → d=-63488, `w_class`=0, no wrap. All weights +127 with `bia`=+32767 → d=63247, `w_class`=1.
- Full DAG run against the picker model with golden Pendigits vectors:
  - exactly 9 `svmready` pulses, spaced 17 cycles apart;
  - `done` at cycle 154;
  - picker winner equals the software prediction.
- Protocol robustness:
  - `start` pulsed again mid-ACC → ignored, results unchanged;
  - `features` toggled after `start` → results unchanged;
  - `rst` asserted in the 5th ACC cycle of decision 3 → IDLE next cycle, no strobe; a fresh `start` then completes normally with correct results.
